core_poll_controller: RTL and testbench

Host-side master for the shared core-selection bus. It sweeps core IDs 0..N-1 and, for each core, broadcasts the ID and pulses the save strobe so exactly one core latches its select bit. It then holds the global output enable until the shared result bus settles, and hands the captured word downstream with a valid/ready handshake. It sits between the array of per-core ID/select modules and the result collector (UART/report path).

---
 rtl/core_poll_pkg.sv | 18 +
 rtl/core_poll_controller_settle.sv | 39 +++
 rtl/core_poll_controller.sv | 126 ++++++++++++
 tb/tb_core_poll_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/core_poll_pkg.sv
// rtl/core_poll_pkg.sv - shared constants and state encoding for the core poll controller
package core_poll_pkg;

    localparam int ID_W = 24;

    // No core carries this ID, so saving it deselects every core.
    localparam logic [ID_W-1:0] NONE_ID = 24'hFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ENABLE,
        ST_PRESENT,
        ST_DESELECT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/core_poll_controller_settle.sv
// rtl/core_poll_controller_settle.sv - down-counter flagging the last bus-settle cycle
module settle_counter #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic last_o
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload while the core is being selected, then count down through the enable window.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/core_poll_controller.sv
// rtl/core_poll_controller.sv - sweeps core IDs, samples the shared result bus, hands words downstream
module core_poll_controller
    import core_poll_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ID_W-1:0]   num_cores_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ID_W-1:0]   core_selection_o,
    output logic              save_selection_o,
    output logic              output_enable_o,
    input  logic [DATA_W-1:0] bus_data_i,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic [ID_W-1:0]   result_core_id_o,
    output logic [DATA_W-1:0] result_data_o
);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     idx_q, idx_d;
    logic [ID_W-1:0]     n_q, n_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ID_W-1:0]     rid_q, rid_d;
    logic                in_reset_q;
    logic                settle_last;

    settle_counter #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load_i(state_q == ST_SELECT),
        .en_i  (state_q == ST_ENABLE),
        .last_o(settle_last)
    );

    // Sweep sequencing and per-state bus outputs; save/enable are mutually exclusive by state.
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        n_d              = n_q;
        data_d           = data_q;
        rid_d            = rid_q;
        core_selection_o = NONE_ID;
        save_selection_o = in_reset_q;
        output_enable_o  = 1'b0;
        result_valid_o   = 1'b0;
        done_o           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    n_d     = num_cores_i;
                    idx_d   = '0;
                    state_d = (num_cores_i == '0) ? ST_DESELECT : ST_SELECT;
                end
            end
            ST_SELECT: begin
                core_selection_o = idx_q;
                save_selection_o = 1'b1;
                state_d          = ST_ENABLE;
            end
            ST_ENABLE: begin
                core_selection_o = idx_q;
                output_enable_o  = 1'b1;
                if (settle_last) begin
                    data_d  = bus_data_i;
                    rid_d   = idx_q;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                core_selection_o = idx_q;
                result_valid_o   = 1'b1;
                if (result_ready_i) begin
                    if (idx_q == n_q - ID_W'(1)) begin
                        state_d = ST_DESELECT;
                    end else begin
                        idx_d   = idx_q + ID_W'(1);
                        state_d = ST_SELECT;
                    end
                end
            end
            ST_DESELECT: begin
                save_selection_o = 1'b1;
                state_d          = ST_DONE;
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any sweep in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            data_q  <= '0;
            rid_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            data_q  <= data_d;
            rid_q   <= rid_d;
        end
    end

    // Remember reset so the deselect broadcast is driven while reset is applied.
    always_ff @(posedge clk_i) begin
        in_reset_q <= rst_i;
    end

    assign busy_o           = (state_q != ST_IDLE);
    assign result_data_o    = data_q;
    assign result_core_id_o = rid_q;

endmodule

// File: tb/tb_core_poll_controller.sv
// tb/tb_core_poll_controller.sv - self-checking bench for core_poll_controller
module tb_core_poll_controller;

    localparam int DATA_W = 32;
    localparam int SETTLE = 2;
    localparam int NCORE  = 8;
    localparam logic [23:0] NONE_ID = 24'hFFFFFF;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [23:0]       num_cores;
    logic              busy, done, save, oe, valid, ready;
    logic [23:0]       core_sel, res_id;
    logic [DATA_W-1:0] bus_data, res_data;

    always #5 clk = ~clk;

    core_poll_controller #(.DATA_W(DATA_W), .SETTLE_CYCLES(SETTLE)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .num_cores_i(num_cores),
        .busy_o(busy), .done_o(done), .core_selection_o(core_sel),
        .save_selection_o(save), .output_enable_o(oe), .bus_data_i(bus_data),
        .result_valid_o(valid), .result_ready_i(ready),
        .result_core_id_o(res_id), .result_data_o(res_data)
    );

    // Behavioural cores: latch select bit on save, drive 0xA0+ID when enabled and selected.
    logic [NCORE-1:0] sel_q = '0;
    always @(posedge clk) begin
        if (save) begin
            for (int i = 0; i < NCORE; i++) sel_q[i] <= (core_sel == 24'(i));
        end
    end
    always_comb begin
        bus_data = '0;
        for (int i = 0; i < NCORE; i++) begin
            if (sel_q[i] && oe) bus_data = DATA_W'(32'hA0 + i);
        end
    end

    typedef struct { logic [23:0] id; logic [DATA_W-1:0] data; } res_t;
    typedef struct { int n; int stall; bit glitch; int exp_done; } vec_t;

    res_t exp_q[$];
    int   checks = 0, fails = 0;
    int   oe_cnt, valid_cyc, none_cnt, done_cnt, hs_cnt, sv_viol, sel_viol;
    bit   hold;
    logic [DATA_W-1:0] hold_data;
    logic [23:0]       hold_id;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Mid-cycle observation: scoreboard pops, stall stability, bus invariants.
    task automatic sample();
        res_t e;
        if (save === 1'b1 && oe === 1'b1) sv_viol++;
        if ($countones(sel_q) > 1) sel_viol++;
        if (oe === 1'b1) oe_cnt++;
        if (valid === 1'b1) valid_cyc++;
        if (save === 1'b1 && core_sel === NONE_ID) none_cnt++;
        if (done === 1'b1) done_cnt++;
        if (valid === 1'b1 && hold) begin
            check_eq("stall_data", res_data, hold_data);
            check_eq("stall_id", res_id, hold_id);
            check_eq("stall_oe", oe, 1'b0);
        end
        hold      = (valid === 1'b1) && !ready;
        hold_data = res_data;
        hold_id   = res_id;
        if (valid === 1'b1 && ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_result", res_id, NONE_ID);
            end else begin
                e = exp_q.pop_front();
                check_eq("result_id", res_id, e.id);
                check_eq("result_data", res_data, e.data);
            end
        end
    endtask

    // One clock: sample at negedge, return 1 time unit after the next rising edge.
    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        oe_cnt = 0; valid_cyc = 0; none_cnt = 0; hs_cnt = 0; sv_viol = 0; sel_viol = 0;
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        int stall_left;
        clear_counts();
        for (int id = 0; id < v.n; id++) exp_q.push_back('{24'(id), DATA_W'(32'hA0 + id)});
        stall_left = v.stall;
        ready      = 1'b1;
        num_cores  = 24'(v.n);
        start      = 1'b1;
        step();
        start     = 1'b0;
        num_cores = 24'h000005;
        cyc       = 1;
        while (!done && cyc < 300) begin
            start = (v.glitch && cyc == 6);
            if (valid && stall_left > 0) begin
                stall_left--;
                ready = 1'b0;
            end else begin
                ready = 1'b1;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        check_eq($sformatf("done_latency_n%0d", v.n), 64'(cyc + 1), 64'(v.exp_done));
        check_eq("busy_at_done", busy, 1'b1);
        step();
        check_eq("busy_after_done", busy, 1'b0);
        check_eq("results_pending", 64'(exp_q.size()), 64'd0);
        check_eq("handshakes", 64'(hs_cnt), 64'(v.n));
        check_eq("none_id_saves", 64'(none_cnt), 64'd1);
        check_eq("save_oe_overlap", 64'(sv_viol), 64'd0);
        check_eq("multi_select", 64'(sel_viol), 64'd0);
        if (v.n == 0) begin
            check_eq("n0_oe_cycles", 64'(oe_cnt), 64'd0);
            check_eq("n0_valid_cycles", 64'(valid_cyc), 64'd0);
        end
        exp_q.delete();
    endtask

    vec_t vecs[4];
    int   done_before;
    int   cyc;

    initial begin
        vecs[0] = '{3, 0, 1'b0, 15};
        vecs[1] = '{0, 0, 1'b0, 3};
        vecs[2] = '{2, 5, 1'b0, 16};
        vecs[3] = '{3, 0, 1'b1, 15};

        rst = 1'b1; start = 1'b0; num_cores = '0; ready = 1'b1;
        hold = 1'b0; done_cnt = 0;
        clear_counts();
        repeat (3) step();
        check_eq("rst_save", save, 1'b1);
        check_eq("rst_core_sel", core_sel, NONE_ID);
        check_eq("rst_oe", oe, 1'b0);
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_data", res_data, '0);
        check_eq("rst_id", res_id, '0);
        rst = 1'b0;
        step();
        check_eq("post_rst_save", save, 1'b0);
        check_eq("post_rst_sel_bits", sel_q, '0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Reset while core 1 of a 4-core sweep is in its enable window.
        clear_counts();
        exp_q.push_back('{24'd0, DATA_W'(32'hA0)});
        num_cores = 24'd4;
        start     = 1'b1;
        step();
        start = 1'b0;
        cyc   = 0;
        while (!(oe && core_sel == 24'd1) && cyc < 100) begin
            step();
            cyc++;
        end
        check_eq("reached_enable_core1", 64'(cyc < 100), 64'd1);
        done_before = done_cnt;
        rst = 1'b1;
        step();
        check_eq("abort_save", save, 1'b1);
        check_eq("abort_core_sel", core_sel, NONE_ID);
        check_eq("abort_oe", oe, 1'b0);
        check_eq("abort_valid", valid, 1'b0);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_data", res_data, '0);
        step();
        rst = 1'b0;
        step();
        check_eq("abort_sel_bits", sel_q, '0);
        check_eq("abort_no_done", 64'(done_cnt - done_before), 64'd0);
        check_eq("abort_results_pending", 64'(exp_q.size()), 64'd0);
        check_eq("abort_multi_select", 64'(sel_viol), 64'd0);
        exp_q.delete();

        run_vec('{1, 0, 1'b0, 7});

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
